food_spawn_ctrl: RTL
====================

// Module: food_spawn_ctrl
// PURPOSE
//  Sequences the free-running 16-bit LFSR output into a legal food cell for the snake grid.
//  On a spawn request it samples rnd, rejects out-of-grid candidates and queries the
//  body-occupancy lookup, retrying until it finds a free cell or exhausts its retry budget.
//  Sits between lfsr16 and the game FSM, which consumes food_x/food_y.
// PARAMETERS
//  GRID_W     32  grid width in cells (2..2**XW)
//  GRID_H     24  grid height in cells (2..2**YW)
//  XW         5   x coordinate width
//  YW         5   y coordinate width
//  MAX_TRIES  64  random candidates (including rejections) before give-up, >=1
// PORTS
//  clk            in   1   system clock
//  resetn         in   1   reset
//  rnd            in   16  LFSR value, changes every clk
//  spawn_req      in   1   request new food; accepted only in IDLE
//  query_valid    out  1   occupancy query strobe (held until resp_valid)
//  query_x        out  XW  candidate x
//  query_y        out  YW  candidate y
//  resp_valid     in   1   occupancy answer valid (>=1 cycle after query_valid)
//  resp_occupied  in   1   1 = candidate cell holds snake body
//  busy           out  1   high in every state except IDLE
//  food_valid     out  1   food_x/food_y hold a placed cell
//  food_x         out  XW  placed food x
//  food_y         out  YW  placed food y
//  spawn_fail     out  1   1-cycle pulse: no free cell found
// BEHAVIOUR
//  Reset resetn, asynchronous, active-low; clock clk. All outputs reset to 0; state IDLE; try counter 0.
//  States: IDLE, SAMPLE, QUERY, DONE, FAIL (+ SCAN with macro).
//  IDLE: spawn_req=1 -> SAMPLE; food_valid cleared same edge; try counter cleared. spawn_req in other states ignored.
//  SAMPLE (1 cycle): cand_x=rnd[XW-1:0], cand_y=rnd[8+YW-1:8], registered; try counter +1.
//   cand_x>=GRID_W or cand_y>=GRID_H -> rejection: tries<MAX_TRIES ? stay SAMPLE : FAIL.
//   else -> QUERY with query_valid=1, query_x/y=candidate.
//  QUERY: query_valid, query_x/y stable until resp_valid. On resp_valid: query_valid drops same edge;
//   occupied=0 -> DONE; occupied=1 -> tries<MAX_TRIES ? SAMPLE : FAIL. resp_valid outside QUERY ignored.
//  DONE (1 cycle): food_x/y <= candidate, food_valid <= 1 -> IDLE. food_valid holds until next accepted spawn_req.
//  FAIL (1 cycle): spawn_fail pulse, food_valid stays 0 -> IDLE.
//  Best-case latency spawn_req -> food_valid: 4 cycles with resp_valid the cycle after query_valid.
//  No modulo arithmetic; rejection sampling only. Try counter width $clog2(MAX_TRIES+1), never wraps.
//  Reset mid-operation: abandon query immediately, outputs to reset values.
// CONFIGURATION
//  FOOD_SCAN_FALLBACK_EN defined: retry exhaustion enters SCAN instead of FAIL. SCAN starts at
//   (0,0) if last candidate out of grid, else last candidate +1 in x; steps x, wrap GRID_W-1->0
//   with y+1, y wraps GRID_H-1->0; each cell queried via same handshake; first free cell -> DONE;
//   GRID_W*GRID_H occupied answers -> FAIL.
//  Undefined: exhaustion -> FAIL directly; no SCAN state or scan counters synthesized.
// TESTING
//  rnd=16'h0305, responder answers free next cycle, spawn_req -> query (5,3), food_valid=1 food=(5,3) at cycle 4.
//  rnd x field 28 (>=GRID_W=24 override) then valid -> no query for rejected sample; tries incremented.
//  Responder always occupied, MAX_TRIES=4, macro off -> exactly 4 queries then spawn_fail 1-cycle pulse, food_valid=0.
//  Same, macro on, only cell (2,1) free -> scan finds (2,1), food_valid=1; all occupied -> 768 queries then spawn_fail.
//  spawn_req held while busy and resp delayed 5 cycles -> single spawn, query fields stable throughout.
//  resetn low during QUERY -> query_valid, busy, food_valid 0 asynchronously; next spawn_req works normally.

Source files
------------

// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: rejection-samples the LFSR into an in-grid, unoccupied cell.
// Optional FOOD_SCAN_FALLBACK_EN adds a linear grid scan once the random retry budget is spent.
module food_spawn_ctrl #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int XW        = 5,
    parameter int YW        = 5,
    parameter int MAX_TRIES = 64
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [15:0]   rnd,
    input  logic          spawn_req,
    output logic          query_valid,
    output logic [XW-1:0] query_x,
    output logic [YW-1:0] query_y,
    input  logic          resp_valid,
    input  logic          resp_occupied,
    output logic          busy,
    output logic          food_valid,
    output logic [XW-1:0] food_x,
    output logic [YW-1:0] food_y,
    output logic          spawn_fail
);

    // state  | meaning
    // IDLE   | waiting for spawn_req
    // SAMPLE | capture a random candidate, reject if outside the grid
    // QUERY  | occupancy query outstanding for query_x/query_y
    // DONE   | free cell placed, food_valid raised
    // FAIL   | no free cell found, spawn_fail pulse
    // SCAN   | (fallback only) issue query for the next cell in raster order
    typedef enum logic [2:0] {
        IDLE, SAMPLE, QUERY, DONE, FAIL
`ifdef FOOD_SCAN_FALLBACK_EN
        , SCAN
`endif
    } state_t;

    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam int XW1 = XW + 1;
    localparam int YW1 = YW + 1;
    localparam logic [TW-1:0]  MT = TW'(MAX_TRIES);
    localparam logic [XW1-1:0] GW = XW1'(GRID_W);
    localparam logic [YW1-1:0] GH = YW1'(GRID_H);

    state_t        state;
    logic [TW-1:0] try_cnt;
    logic [TW-1:0] try_inc;
    logic [XW-1:0] rx;
    logic [YW-1:0] ry;
    logic          in_grid;
    logic          unused_rnd;

    assign rx         = rnd[XW-1:0];
    assign ry         = rnd[8+YW-1:8];
    assign in_grid    = ({1'b0, rx} < GW) && ({1'b0, ry} < GH);
    assign try_inc    = try_cnt + 1'b1;
    assign unused_rnd = ^{rnd[15:8+YW], rnd[7:XW]};

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam int SW = $clog2(GRID_W * GRID_H + 1);
    localparam logic [SW-1:0] LAST_CELL = SW'(GRID_W * GRID_H - 1);
    localparam logic [XW-1:0] XMAX      = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX      = YW'(GRID_H - 1);

    logic          scanning;
    logic [SW-1:0] scan_cnt;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;

    // Raster successor of the current query cell, wrapping at both grid edges.
    always_comb begin
        nx = query_x + 1'b1;
        ny = query_y;
        if (query_x == XMAX) begin
            nx = '0;
            ny = (query_y == YMAX) ? '0 : query_y + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            try_cnt     <= '0;
            query_valid <= 1'b0;
            query_x     <= '0;
            query_y     <= '0;
            busy        <= 1'b0;
            food_valid  <= 1'b0;
            food_x      <= '0;
            food_y      <= '0;
            spawn_fail  <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            scanning    <= 1'b0;
            scan_cnt    <= '0;
`endif
        end else begin
            spawn_fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (spawn_req) begin
                        state      <= SAMPLE;
                        busy       <= 1'b1;
                        food_valid <= 1'b0;
                        try_cnt    <= '0;
`ifdef FOOD_SCAN_FALLBACK_EN
                        scanning   <= 1'b0;
                        scan_cnt   <= '0;
`endif
                    end
                end
                SAMPLE: begin
                    try_cnt <= try_inc;
                    query_x <= rx;
                    query_y <= ry;
                    if (in_grid) begin
                        state       <= QUERY;
                        query_valid <= 1'b1;
                    end else if (try_inc < MT) begin
                        state <= SAMPLE;
                    end else begin
`ifdef FOOD_SCAN_FALLBACK_EN
                        // Last candidate was off-grid, so the scan starts at the origin.
                        state    <= SCAN;
                        scanning <= 1'b1;
                        query_x  <= '0;
                        query_y  <= '0;
`else
                        state      <= FAIL;
                        spawn_fail <= 1'b1;
`endif
                    end
                end
                QUERY: begin
                    if (resp_valid) begin
                        query_valid <= 1'b0;
                        if (!resp_occupied) begin
                            state      <= DONE;
                            food_valid <= 1'b1;
                            food_x     <= query_x;
                            food_y     <= query_y;
                        end
`ifdef FOOD_SCAN_FALLBACK_EN
                        else if (scanning) begin
                            if (scan_cnt == LAST_CELL) begin
                                state      <= FAIL;
                                spawn_fail <= 1'b1;
                            end else begin
                                scan_cnt <= scan_cnt + 1'b1;
                                state    <= SCAN;
                                query_x  <= nx;
                                query_y  <= ny;
                            end
                        end
`endif
                        else if (try_cnt < MT) begin
                            state <= SAMPLE;
                        end else begin
`ifdef FOOD_SCAN_FALLBACK_EN
                            state    <= SCAN;
                            scanning <= 1'b1;
                            query_x  <= nx;
                            query_y  <= ny;
`else
                            state      <= FAIL;
                            spawn_fail <= 1'b1;
`endif
                        end
                    end
                end
`ifdef FOOD_SCAN_FALLBACK_EN
                SCAN: begin
                    query_valid <= 1'b1;
                    state       <= QUERY;
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                FAIL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
